// File: rtl/adpll_lock_detector.sv
// rtl/adpll_lock_detector.sv - ADPLL phase-error lock detector with hysteresis, loss counter and reference watchdog
// Optional DCO control-code span statistics enabled by defining ADPLL_LOCK_DCO_STATS_EN.
module adpll_lock_detector #(
  parameter int LOCK_THRESH    = 2,
  parameter int UNLOCK_THRESH  = 6,
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic        fpga_clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic [7:0]  error_i,
  input  logic        error_valid_i,
  input  logic [8:0]  dco_cc_i,
  output logic        locked_o,
  output logic [1:0]  state_o,
  output logic [7:0]  loss_count_o,
  output logic        timeout_o
`ifdef ADPLL_LOCK_DCO_STATS_EN
  ,
  output logic [9:0]  dco_span_o
`endif
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    SLIP     = 2'd3
  } state_e;

  localparam logic [6:0]  LOCK_TH   = 7'(LOCK_THRESH);
  localparam logic [6:0]  UNLOCK_TH = 7'(UNLOCK_THRESH);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_N  = 8'(UNLOCK_COUNT);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        timeout_q, timeout_d;

  logic [7:0]  neg_e;
  logic [6:0]  abs_e;
  logic        in_lock;
  logic        is_slip;
  logic [7:0]  run_inc;
  logic [15:0] idle_inc;
  logic        lose;

  // -128 has no positive 8-bit counterpart, so its magnitude clamps to 127.
  always_comb begin
    neg_e   = 8'd0 - error_i;
    abs_e   = error_i[7] ? (neg_e[7] ? 7'h7f : neg_e[6:0]) : error_i[6:0];
    in_lock = (abs_e <= LOCK_TH);
    is_slip = (abs_e > UNLOCK_TH);
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    idle_cnt_d = idle_cnt_q;
    loss_cnt_d = loss_cnt_q;
    timeout_d  = timeout_q;
    lose       = 1'b0;
    run_inc    = run_cnt_q + 8'd1;
    idle_inc   = idle_cnt_q + 16'd1;

    if (!enable_i) begin
      state_d    = UNLOCKED;
      run_cnt_d  = 8'd0;
      idle_cnt_d = 16'd0;
    end else if (error_valid_i) begin
      idle_cnt_d = 16'd0;
      timeout_d  = 1'b0;
      case (state_q)
        UNLOCKED: begin
          if (in_lock) begin
            state_d   = ACQUIRE;
            run_cnt_d = 8'd1;
          end
        end
        ACQUIRE: begin
          if (!in_lock) begin
            state_d   = UNLOCKED;
            run_cnt_d = 8'd0;
          end else if (run_inc == LOCK_N) begin
            state_d   = LOCKED;
            run_cnt_d = 8'd0;
          end else begin
            run_cnt_d = run_inc;
          end
        end
        LOCKED: begin
          if (is_slip) begin
            state_d   = SLIP;
            run_cnt_d = 8'd1;
          end
        end
        SLIP: begin
          if (!is_slip) begin
            state_d   = LOCKED;
            run_cnt_d = 8'd0;
          end else if (run_inc == UNLOCK_N) begin
            state_d   = UNLOCKED;
            run_cnt_d = 8'd0;
            lose      = 1'b1;
          end else begin
            run_cnt_d = run_inc;
          end
        end
        default: begin
          state_d   = UNLOCKED;
          run_cnt_d = 8'd0;
        end
      endcase
    end else if (idle_cnt_q != TIMEOUT_N) begin
      // The idle counter parks at the limit so the timeout event fires only once.
      idle_cnt_d = idle_inc;
      if (idle_inc == TIMEOUT_N) begin
        state_d   = UNLOCKED;
        run_cnt_d = 8'd0;
        timeout_d = 1'b1;
        lose      = (state_q == LOCKED) || (state_q == SLIP);
      end
    end

    if (lose && (loss_cnt_q != 8'hff)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_ni) begin
      state_q    <= UNLOCKED;
      run_cnt_q  <= 8'd0;
      idle_cnt_q <= 16'd0;
      loss_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state_o      = state_q;
  assign locked_o     = (state_q == LOCKED) || (state_q == SLIP);
  assign loss_count_o = loss_cnt_q;
  assign timeout_o    = timeout_q;

`ifdef ADPLL_LOCK_DCO_STATS_EN
  logic [8:0] dco_min_q, dco_min_d;
  logic [8:0] dco_max_q, dco_max_d;
  logic [9:0] dco_span_q, dco_span_d;

  always_comb begin
    dco_min_d = dco_min_q;
    dco_max_d = dco_max_q;
    if (enable_i && error_valid_i) begin
      if ((state_q == ACQUIRE) && (state_d == LOCKED)) begin
        dco_min_d = dco_cc_i;
        dco_max_d = dco_cc_i;
      end else if ((state_q == LOCKED) || (state_q == SLIP)) begin
        if ($signed(dco_cc_i) < $signed(dco_min_q)) dco_min_d = dco_cc_i;
        if ($signed(dco_cc_i) > $signed(dco_max_q)) dco_max_d = dco_cc_i;
      end
    end
    // max >= min always holds, so the sign-extended difference is non-negative.
    dco_span_d = {dco_max_d[8], dco_max_d} - {dco_min_d[8], dco_min_d};
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_ni) begin
      dco_min_q  <= 9'd0;
      dco_max_q  <= 9'd0;
      dco_span_q <= 10'd0;
    end else begin
      dco_min_q  <= dco_min_d;
      dco_max_q  <= dco_max_d;
      dco_span_q <= dco_span_d;
    end
  end

  assign dco_span_o = dco_span_q;
`else
  logic unused_dco;
  assign unused_dco = ^dco_cc_i;
`endif

endmodule

// File: tb/tb_adpll_lock_detector.sv
// tb/tb_adpll_lock_detector.sv - directed self-checking bench for adpll_lock_detector
module tb_adpll_lock_detector;

  logic       fpga_clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       enable_i = 1'b1;
  logic [7:0] error_i = 8'd0;
  logic       error_valid_i = 1'b0;
  logic [8:0] dco_cc_i = 9'd0;
  logic       locked_o;
  logic [1:0] state_o;
  logic [7:0] loss_count_o;
  logic       timeout_o;
`ifdef ADPLL_LOCK_DCO_STATS_EN
  logic [9:0] dco_span_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int bad_lock = 0;

  adpll_lock_detector dut (
    .fpga_clk_i    (fpga_clk_i),
    .reset_ni      (reset_ni),
    .enable_i      (enable_i),
    .error_i       (error_i),
    .error_valid_i (error_valid_i),
    .dco_cc_i      (dco_cc_i),
    .locked_o      (locked_o),
    .state_o       (state_o),
    .loss_count_o  (loss_count_o),
    .timeout_o     (timeout_o)
`ifdef ADPLL_LOCK_DCO_STATS_EN
    ,
    .dco_span_o    (dco_span_o)
`endif
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] e);
    error_i = e;
    error_valid_i = 1'b1;
    @(posedge fpga_clk_i);
    #1;
    error_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge fpga_clk_i);
    #1;
  endtask

  initial begin
    // Reset held three cycles.
    reset_ni = 1'b0;
    idle(1);
    check("rst_state_c1", state_o, 0);
    idle(2);
    check("rst_state", state_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_loss", loss_count_o, 0);
    check("rst_timeout", timeout_o, 0);
    reset_ni = 1'b1;

    // Lock acquisition: locked_o rises right after the 16th sample.
    repeat (15) send(8'd0);
    check("acq_15_state", state_o, 1);
    check("acq_15_locked", locked_o, 0);
    send(8'd0);
    check("acq_16_locked", locked_o, 1);
    check("acq_16_state", state_o, 2);
    repeat (4) send(8'd0);
    check("acq_20_state", state_o, 2);

    // Disable while locked: no loss counted.
    enable_i = 1'b0;
    idle(1);
    check("en_state", state_o, 0);
    check("en_locked", locked_o, 0);
    check("en_loss", loss_count_o, 0);
    send(8'd0);
    check("en_ignore_valid", state_o, 0);
    enable_i = 1'b1;

    // Acquire abort at |e|=3, then relock on -2.
    for (int i = 0; i < 10; i++) begin
      send(8'd1);
      if (locked_o) bad_lock++;
    end
    check("abort_acq_state", state_o, 1);
    send(8'd3);
    check("abort_state", state_o, 0);
    check("abort_never_locked", bad_lock, 0);
    repeat (16) send(8'hfe);
    check("neg2_locked", locked_o, 1);

    // Hysteresis band holds lock.
    for (int i = 0; i < 50; i++) begin
      send(8'd5);
      if (state_o != 2'd2) bad_lock++;
    end
    check("hyst_held", bad_lock, 0);
    repeat (3) send(8'd7);
    check("slip_state", state_o, 3);
    check("slip_locked", locked_o, 1);
    send(8'd0);
    check("slip_recover", state_o, 2);
    check("slip_loss", loss_count_o, 0);
    repeat (3) send(8'hf9);
    check("slip3_state", state_o, 3);
    send(8'hf9);
    check("unlock_state", state_o, 0);
    check("unlock_loss", loss_count_o, 1);

    // -128 clamps to 127 and slips.
    repeat (16) send(8'd0);
    check("relock1", state_o, 2);
    send(8'h80);
    check("m128_slip", state_o, 3);
    repeat (3) send(8'h80);
    check("m128_unlock", state_o, 0);
    check("m128_loss", loss_count_o, 2);

    // Watchdog fires on the 128th idle cycle.
    repeat (16) send(8'd0);
    idle(127);
    check("wd_127_state", state_o, 2);
    check("wd_127_timeout", timeout_o, 0);
    idle(1);
    check("wd_state", state_o, 0);
    check("wd_timeout", timeout_o, 1);
    check("wd_loss", loss_count_o, 3);
    idle(20);
    check("wd_sticky", timeout_o, 1);
    send(8'd0);
    check("wd_clear", timeout_o, 0);
    check("wd_acquire", state_o, 1);

    // Valid landing on the timeout cycle wins.
    repeat (15) send(8'd0);
    check("relock2", state_o, 2);
    idle(127);
    send(8'd0);
    check("wd_race_state", state_o, 2);
    check("wd_race_timeout", timeout_o, 0);
    idle(1);
    check("wd_race_after", state_o, 2);
    check("wd_race_loss", loss_count_o, 3);

    // Loss counter saturates.
    for (int i = 0; i < 260; i++) begin
      repeat (16) send(8'd0);
      repeat (4) send(8'd7);
    end
    check("sat_loss", loss_count_o, 255);
    check("sat_state", state_o, 0);

`ifdef ADPLL_LOCK_DCO_STATS_EN
    dco_cc_i = 9'd10;
    repeat (16) send(8'd0);
    check("dco_entry_span", dco_span_o, 0);
    dco_cc_i = 9'h1ec;
    send(8'd0);
    check("dco_min_span", dco_span_o, 30);
    dco_cc_i = 9'd40;
    send(8'd0);
    check("dco_span", dco_span_o, 60);
    enable_i = 1'b0;
    idle(1);
    check("dco_hold", dco_span_o, 60);
    enable_i = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detector.md
Name: adpll_lock_detector

Overview:
- Downstream consumer of the ADPLL's signed phase-error output; runs in the FPGA fast-clock domain (258 MHz).
- Qualifies each ref-period error sample against lock/unlock thresholds with hysteresis.
- Provides a registered lock flag, state code, loss-of-lock counter and reference-loss watchdog.
- Outputs feed the display interface and top-level status LEDs.

Parameters:
- LOCK_THRESH, 2: max |error| counted as in-lock while acquiring.
- UNLOCK_THRESH, 6: |error| above this counts as a slip while locked; must be >= LOCK_THRESH.
- LOCK_COUNT, 16: consecutive in-threshold samples required to declare lock; range 2..255.
- UNLOCK_COUNT, 4: consecutive slip samples required to drop lock; range 2..255.
- TIMEOUT_CYCLES, 128: fpga_clk_i cycles without error_valid_i before reference loss is declared; range 2..65535.

Ports:
- fpga_clk_i  in  1  fast system clock; all logic on its rising edge.
- reset_ni  in  1  synchronous, active-low reset.
- enable_i  in  1  detector enable; low forces UNLOCKED and clears run counters.
- error_i  in  8  signed phase error from the ADPLL, two's complement.
- error_valid_i  in  1  one-cycle strobe; error_i is sampled on the cycle this strobe is high (once per ref period).
- dco_cc_i  in  9  signed DCO control code; used only with the optional feature.
- locked_o  out  1  high in LOCKED and SLIP.
- state_o  out  2  0=UNLOCKED, 1=ACQUIRE, 2=LOCKED, 3=SLIP.
- loss_count_o  out  8  count of lock losses (LOCKED/SLIP to UNLOCKED); saturates at 255.
- timeout_o  out  1  sticky reference-loss flag.
- dco_span_o  out  10  max minus min dco_cc while locked; present only when the optional macro is defined.

Behaviour:
- Reset (reset_ni low at a clock edge): state=UNLOCKED. All counters, locked_o, timeout_o, loss_count_o and dco_span_o are zero. Reset overrides every other input.
- abs_e = |error_i|. error_i = -128 saturates to 127. Compare unsigned 7-bit values.
- Latency: state, locked_o and counters update on the clock edge that samples error_valid_i. They are visible the following cycle. No other cycle changes state except timeout and enable events.
- Run counter run_cnt is 8 bits. Each state transition clears it to 0 unless a transition below states otherwise.
- UNLOCKED, on valid: if abs_e <= LOCK_THRESH, go to ACQUIRE with run_cnt=1. Otherwise stay.
- ACQUIRE, on valid:
  - abs_e <= LOCK_THRESH: run_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED.
  - Otherwise go to UNLOCKED.
- LOCKED, on valid: if abs_e > UNLOCK_THRESH, go to SLIP with run_cnt=1. Otherwise stay (hysteresis band LOCK_THRESH < abs_e <= UNLOCK_THRESH keeps lock).
- SLIP, on valid:
  - abs_e > UNLOCK_THRESH: run_cnt++. When it equals UNLOCK_COUNT, go to UNLOCKED and increment loss_count_o.
  - Otherwise return to LOCKED.
- Watchdog:
  - 16-bit idle counter clears on every valid and increments otherwise.
  - On reaching TIMEOUT_CYCLES: go to UNLOCKED from any state, set timeout_o, clear run_cnt. If the state was LOCKED or SLIP, also increment loss_count_o.
  - The idle counter holds at TIMEOUT_CYCLES until the next valid.
  - timeout_o clears on the next valid sample; that sample is also evaluated normally from UNLOCKED.
- Simultaneous valid and timeout: valid wins. The idle counter clears and no timeout occurs.
- enable_i low:
  - state=UNLOCKED; run_cnt and the idle counter are cleared; valid strobes are ignored.
  - loss_count_o and timeout_o hold.
  - A drop from LOCKED/SLIP caused by enable going low does not count as a loss.
- loss_count_o saturates at 255 and never wraps.

Optional Feature:
- Macro ADPLL_LOCK_DCO_STATS_EN.
- When defined:
  - Registers dco_min/dco_max (signed 9-bit) are loaded with dco_cc_i on entry to LOCKED from ACQUIRE.
  - They update on every valid sample while in LOCKED or SLIP.
  - dco_span_o = dco_max - dco_min, computed as a 10-bit unsigned value. It is registered and holds its last value after lock is lost, until the next lock entry or reset.
- When undefined: the port and registers do not exist.

Test Plan:
- Reset check: reset_ni low 3 cycles, then 20 valids with error_i=0 (LOCK_COUNT=16). Required: state_o=0 during reset; locked_o rises exactly one cycle after the 16th valid.
- Acquire abort: 10 valids with error_i=1, then one with error_i=3. Required: state_o returns to 0 and locked_o never rises; then 16 valids with error_i=-2 → locked_o=1.
- Hysteresis and slip: when locked, send error_i=5 ×50 → stays LOCKED. Then 3× error_i=7 followed by error_i=0 → SLIP then back to LOCKED, loss_count_o=0. Then 4× error_i=-7 → UNLOCKED, loss_count_o=1.
- Saturated magnitude: error_i=-128 while locked is treated as abs 127 (slip). 4 such samples → unlock.
- Watchdog: when locked, withhold valid for 128 cycles → state_o=0, timeout_o=1, loss_count_o increments. Next valid with error_i=0 clears timeout_o and enters ACQUIRE. Valid on exactly cycle 128 → no timeout.
- Enable, plus DCO span if the macro is defined: drop enable_i while locked → state_o=0, loss_count_o unchanged. With ADPLL_LOCK_DCO_STATS_EN: lock with dco_cc_i=10, then samples -20 and 40 → dco_span_o=60.
